// File: rtl/first_nios2_system_pkg.sv
// Shared definitions for the first_nios2_system sysid checker.
//   state_t  : checker FSM state encoding
//   WORD_ID  : Avalon word address of the system ID register
//   WORD_TS  : Avalon word address of the timestamp register
//   CNT_W    : width of the per-phase timeout counter
//   DATA_W   : width of the sysid slave data bus
package first_nios2_system_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  localparam logic WORD_ID = 1'b0;
  localparam logic WORD_TS = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_ID  = 3'd1,
    WAIT_ID = 3'd2,
    REQ_TS  = 3'd3,
    WAIT_TS = 3'd4,
    FINISH  = 3'd5
  } state_t;

endpackage

// File: rtl/first_nios2_system_sysid_checker.sv
// Reads the system ID (word 0) and build timestamp (word 1) from a sysid
// Avalon-MM slave and compares them against the values this image expects.
//
// Ports:
//   clock, reset_n         : clock and asynchronous active-low reset
//   start                  : one-cycle pulse, ignored while busy
//   avm_address, avm_read  : Avalon-MM master request
//   avm_waitrequest        : slave stall
//   avm_readdata/_valid    : slave response (pipelined reads supported)
//   id_value, timestamp_value : captured words (held if a read aborts)
//   busy                   : high in every state but IDLE
//   done                   : one-cycle pulse in FINISH
//   id_match, ts_match     : comparison results, valid from FINISH on
//   timeout_err            : a read phase ran TIMEOUT_CYCLES without data
module first_nios2_system_sysid_checker
  import first_nios2_system_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1365185748,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
  logic [DATA_W-1:0] id_n, ts_n;
  logic              is_req, ts_phase, in_phase, capture, timeout_hit;
  logic              enter_finish;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    id_n        = id_value;
    ts_n        = timestamp_value;
    timeout_hit = 1'b0;

    is_req   = (state == REQ_ID) || (state == REQ_TS);
    ts_phase = (state == REQ_TS) || (state == WAIT_TS);
    in_phase = is_req || (state == WAIT_ID) || (state == WAIT_TS);
    cnt_inc  = cnt + 1'b1;

    // Data counts in a REQ state only on the cycle the request is accepted;
    // a response arriving while the slave still stalls belongs to nobody.
    capture = in_phase && avm_readdatavalid && (!is_req || !avm_waitrequest);

    if (in_phase) begin
      if (capture) begin
        // Completion wins over a timeout falling on the same cycle.
        cnt_n = '0;
        if (ts_phase) begin
          ts_n    = avm_readdata;
          state_n = FINISH;
        end else begin
          id_n    = avm_readdata;
          state_n = REQ_TS;
        end
      end else if (cnt_inc == TIMEOUT_LIM) begin
        cnt_n       = cnt_inc;
        timeout_hit = 1'b1;
        state_n     = FINISH;
      end else begin
        cnt_n = cnt_inc;
        if (is_req && !avm_waitrequest) begin
          state_n = ts_phase ? WAIT_TS : WAIT_ID;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_n = REQ_ID;
            cnt_n   = '0;
          end
        end
        FINISH:  state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  assign enter_finish = (state_n == FINISH) && (state != FINISH);

  // Results are refreshed from the values being committed on the edge into
  // FINISH so they are already valid while done is high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt             <= '0;
      id_value        <= '0;
      timestamp_value <= '0;
      id_match        <= 1'b0;
      ts_match        <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      cnt             <= cnt_n;
      id_value        <= id_n;
      timestamp_value <= ts_n;
      if ((state == IDLE) && start) begin
        timeout_err <= 1'b0;
      end
      if (enter_finish) begin
        id_match    <= (id_n == EXPECTED_ID);
        ts_match    <= (ts_n == EXPECTED_TIMESTAMP);
        timeout_err <= timeout_hit;
      end
    end
  end

  assign avm_read    = (state == REQ_ID) || (state == REQ_TS);
  assign avm_address = (state == REQ_TS) ? WORD_TS : WORD_ID;
  assign busy        = (state != IDLE);
  assign done        = (state == FINISH);

endmodule
